// File: rtl/fir_mac_pkg.sv
// Shared types and helpers for the time-multiplexed FIR MAC.
package fir_mac_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, ACC, DONE} firState_e;

    // Result of the round/saturate step: the clipped value plus a clip flag.
    typedef struct packed {
        logic              sat;
        logic signed [63:0] val;
    } roundSat_t;

    // The accumulator is wide enough to sum MAX_TAPS full-scale products without wrapping.
    function automatic int accWidth(input int inW, input int coeffW, input int maxTaps);
        return inW + coeffW + $clog2(maxTaps);
    endfunction

    // Round half-up by adding half an LSB before the arithmetic shift, then clip to outW bits.
    function automatic roundSat_t roundSat(input logic signed [63:0] acc, input int shift,
                                           input int outW);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        roundSat_t          res;
        r = acc;
        if (shift > 0) r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (outW - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (outW - 1));
        res.sat = (r > hi) || (r < lo);
        res.val = (r > hi) ? hi : ((r < lo) ? lo : r);
        return res;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Coefficient register file: RAM-style write, registered readback, combinational MAC tap read.
module fir_coeff_bank #(
    parameter int MAX_TAPS = 33,
    parameter int COEFF_W  = 16,
    parameter int ADDR_W   = 6
) (
    input  logic               iClk_12M,
    input  logic               iRsn,
    input  logic               iWrEn,
    input  logic               iRdEn,
    input  logic [ADDR_W-1:0]  iAddr,
    input  logic [COEFF_W-1:0] iWrDt,
    output logic [COEFF_W-1:0] oRdDt,
    input  logic [ADDR_W-1:0]  iMacIdx,
    output logic [COEFF_W-1:0] oMacCoeff
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MAX_TAPS - 1);

    logic [MAX_TAPS-1:0][COEFF_W-1:0] coeff;
    logic                             addrOk;

    // Addresses past the bank are dropped on write and read back as zero.
    assign addrOk    = (iAddr <= LastAddr);
    assign oMacCoeff = (iMacIdx <= LastAddr) ? coeff[iMacIdx] : '0;

    // Bank storage and readback register; readback holds when no read is issued.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            coeff <= '0;
            oRdDt <= '0;
        end else begin
            if (iWrEn && addrOk) coeff[iAddr] <= iWrDt;
            if (iRdEn) oRdDt <= addrOk ? coeff[iAddr] : '0;
        end
    end

endmodule

// File: rtl/param_fir_mac.sv
// Reconfigurable FIR: delay line, control FSM and one MAC that walks the taps one per clock.
module param_fir_mac
    import fir_mac_pkg::*;
#(
    parameter int IN_W     = 3,
    parameter int COEFF_W  = 16,
    parameter int OUT_W    = 16,
    parameter int MAX_TAPS = 33,
    parameter int SHIFT    = 0,
    parameter int ADDR_W   = 6
) (
    input  logic                    iClk_12M,
    input  logic                    iRsn,
    input  logic                    iEnSample,
    input  logic                    iCoeffUpdate,
    input  logic                    iCsnCoeff,
    input  logic                    iWrnCoeff,
    input  logic [ADDR_W-1:0]       iAddrCoeff,
    input  logic [COEFF_W-1:0]      iWrDtCoeff,
    output logic [COEFF_W-1:0]      oRdDtCoeff,
    input  logic [ADDR_W-1:0]       iNumOfTaps,
    input  logic signed [IN_W-1:0]  iFirIn,
    output logic signed [OUT_W-1:0] oFirOut,
    output logic                    oValid,
    output logic                    oSat,
    output logic                    oBusy,
    output logic                    oOverrun
);

    localparam int                ACC_W = accWidth(IN_W, COEFF_W, MAX_TAPS);
    localparam int                PROD_W = IN_W + COEFF_W;
    localparam logic [ADDR_W-1:0] MaxN = ADDR_W'(MAX_TAPS);

    firState_e                     state, nextState;
    logic [MAX_TAPS-1:0][IN_W-1:0] xLine;
    logic [ADDR_W-1:0]             numTaps, idx, nLatch;
    logic signed [ACC_W-1:0]       acc;
    logic [COEFF_W-1:0]            macCoeff;
    logic signed [PROD_W-1:0]      prod;
    roundSat_t                     rs;
    logic                          unusedRsBits;
    logic                          startSample, shiftLine, wrEn, rdEn;

    // A sample only starts a computation from IDLE; in LOAD it just primes the delay line.
    assign startSample = (state == IDLE) && !iCoeffUpdate && iEnSample;
    assign shiftLine   = startSample || ((state == LOAD) && iEnSample);
    assign nLatch      = (iNumOfTaps == '0) ? ADDR_W'(1)
                       : ((iNumOfTaps > MaxN) ? MaxN : iNumOfTaps);
    assign prod        = PROD_W'($signed(xLine[idx])) * PROD_W'($signed(macCoeff));
    assign rs          = roundSat(64'(acc), SHIFT, OUT_W);
    assign unusedRsBits = ^rs.val[63:OUT_W];
    assign wrEn        = (state == LOAD) && !iCsnCoeff && !iWrnCoeff;
    assign rdEn        = !iCsnCoeff && iWrnCoeff;
    assign oBusy       = (state != IDLE);

    fir_coeff_bank #(
        .MAX_TAPS(MAX_TAPS),
        .COEFF_W (COEFF_W),
        .ADDR_W  (ADDR_W)
    ) uBank (
        .iClk_12M (iClk_12M),
        .iRsn     (iRsn),
        .iWrEn    (wrEn),
        .iRdEn    (rdEn),
        .iAddr    (iAddrCoeff),
        .iWrDt    (iWrDtCoeff),
        .oRdDt    (oRdDtCoeff),
        .iMacIdx  (idx),
        .oMacCoeff(macCoeff)
    );

    // State register.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) state <= IDLE;
        else       state <= nextState;
    end

    // Next state: load requests win over samples; a running computation always finishes.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (iCoeffUpdate)   nextState = LOAD;
                else if (iEnSample) nextState = ACC;
            end
            LOAD:    if (!iCoeffUpdate) nextState = IDLE;
            ACC:     if (idx == numTaps - ADDR_W'(1)) nextState = DONE;
            DONE:    nextState = iCoeffUpdate ? LOAD : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Delay line, MAC accumulation, output register and strobes.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            xLine    <= '0;
            numTaps  <= '0;
            idx      <= '0;
            acc      <= '0;
            oFirOut  <= '0;
            oValid   <= 1'b0;
            oSat     <= 1'b0;
            oOverrun <= 1'b0;
        end else begin
            oValid   <= 1'b0;
            oOverrun <= iEnSample && ((state == ACC) || (state == DONE));
            if (shiftLine) xLine <= {xLine[MAX_TAPS-2:0], iFirIn};
            if (startSample) begin
                numTaps <= nLatch;
                acc     <= '0;
                idx     <= '0;
            end else if (state == ACC) begin
                acc <= acc + ACC_W'(prod);
                idx <= idx + ADDR_W'(1);
            end
            if (state == DONE) begin
                oFirOut <= rs.val[OUT_W-1:0];
                oSat    <= rs.sat;
                oValid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_param_fir_mac.sv
// Directed bench for param_fir_mac: default instance plus a SHIFT=2 instance for rounding.
module tb_param_fir_mac;

    logic               clk = 1'b0;
    logic               rstN, enSample, enSample2, coeffUpdate, coeffUpdate2, csn, wrn;
    logic [5:0]         addr, numTaps;
    logic [15:0]        wrDt, rdDt, rdDt2;
    logic signed [2:0]  firIn;
    logic signed [15:0] firOut, firOut2;
    logic               valid, sat, busy, overrun, valid2, sat2, busy2, overrun2;
    int                 checks = 0;
    int                 errors = 0;

    always #5 clk = ~clk;

    param_fir_mac uDut (
        .iClk_12M(clk), .iRsn(rstN), .iEnSample(enSample), .iCoeffUpdate(coeffUpdate),
        .iCsnCoeff(csn), .iWrnCoeff(wrn), .iAddrCoeff(addr), .iWrDtCoeff(wrDt),
        .oRdDtCoeff(rdDt), .iNumOfTaps(numTaps), .iFirIn(firIn), .oFirOut(firOut),
        .oValid(valid), .oSat(sat), .oBusy(busy), .oOverrun(overrun)
    );

    param_fir_mac #(.SHIFT(2)) uDut2 (
        .iClk_12M(clk), .iRsn(rstN), .iEnSample(enSample2), .iCoeffUpdate(coeffUpdate2),
        .iCsnCoeff(csn), .iWrnCoeff(wrn), .iAddrCoeff(addr), .iWrDtCoeff(wrDt),
        .oRdDtCoeff(rdDt2), .iNumOfTaps(numTaps), .iFirIn(firIn), .oFirOut(firOut2),
        .oValid(valid2), .oSat(sat2), .oBusy(busy2), .oOverrun(overrun2)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic coefWrite(input logic [5:0] a, input logic [15:0] d);
        csn = 1'b0; wrn = 1'b0; addr = a; wrDt = d;
        @(negedge clk);
        csn = 1'b1; wrn = 1'b1;
    endtask

    task automatic coefRead(input logic [5:0] a, output logic [15:0] d);
        csn = 1'b0; wrn = 1'b1; addr = a;
        @(negedge clk);
        d = rdDt;
        csn = 1'b1;
    endtask

    // Strobe one sample into the selected instance and wait (bounded) for its oValid.
    task automatic runSample(input bit sel, input logic signed [2:0] din,
                             output longint val, output logic s, output int lat);
        bit seen;
        if (sel) enSample2 = 1'b1; else enSample = 1'b1;
        firIn = din;
        @(negedge clk);
        enSample = 1'b0; enSample2 = 1'b0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            if (sel ? valid2 : valid) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check("validSeen", longint'(seen), 1);
        val = sel ? longint'(firOut2) : longint'(firOut);
        s   = sel ? sat2 : sat;
    endtask

    initial begin
        longint      v;
        logic        s;
        int          lat;
        logic [15:0] rd;
        int          nValid, nOv;

        rstN = 1'b0; enSample = 1'b0; enSample2 = 1'b0; coeffUpdate = 1'b0;
        coeffUpdate2 = 1'b0; csn = 1'b1; wrn = 1'b1; addr = '0; wrDt = '0;
        numTaps = 6'd33; firIn = '0;
        repeat (2) @(negedge clk);
        check("rstFirOut", longint'(firOut), 0);
        check("rstValid", longint'(valid), 0);
        check("rstSat", longint'(sat), 0);
        check("rstBusy", longint'(busy), 0);
        check("rstOverrun", longint'(overrun), 0);
        check("rstRdDt", longint'(rdDt), 0);
        rstN = 1'b1;
        @(negedge clk);

        // Coefficient load and readback.
        coeffUpdate = 1'b1;
        @(negedge clk);
        check("loadBusy", longint'(busy), 1);
        for (int k = 0; k < 33; k++) coefWrite(6'(k), 16'(k + 1));
        coefRead(6'd5, rd);   check("rdAddr5", longint'(rd), 6);
        coefRead(6'd32, rd);  check("rdAddr32", longint'(rd), 33);
        coefRead(6'd40, rd);  check("rdAddr40", longint'(rd), 0);
        coefWrite(6'd40, 16'h1234);
        coefRead(6'd40, rd);  check("rdAddr40AfterWr", longint'(rd), 0);
        coefRead(6'd8, rd);   check("rdAddr8AfterWr", longint'(rd), 9);
        coeffUpdate = 1'b0;
        @(negedge clk);

        // Impulse response, 33 taps.
        numTaps = 6'd33;
        for (int j = 0; j < 34; j++) begin
            runSample(1'b0, (j == 0) ? 3'sd1 : 3'sd0, v, s, lat);
            check($sformatf("imp33[%0d]", j), v, (j < 33) ? j + 1 : 0);
            if (j == 0) check("lat33", longint'(lat), 34);
            if (j == 0 || j == 32) check($sformatf("imp33Sat[%0d]", j), longint'(s), 0);
        end

        // Impulse response, 10 taps, then N=0 treated as one tap.
        numTaps = 6'd10;
        for (int j = 0; j < 11; j++) begin
            runSample(1'b0, (j == 0) ? 3'sd1 : 3'sd0, v, s, lat);
            check($sformatf("imp10[%0d]", j), v, (j < 10) ? j + 1 : 0);
            if (j == 0) check("lat10", longint'(lat), 11);
        end
        numTaps = 6'd0;
        runSample(1'b0, 3'sd1, v, s, lat);
        check("impN0First", v, 1);
        check("latN0", longint'(lat), 2);
        runSample(1'b0, 3'sd0, v, s, lat);
        check("impN0Second", v, 0);

        // Saturation with full-scale coefficients.
        coeffUpdate = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 33; k++) coefWrite(6'(k), 16'h7FFF);
        coeffUpdate = 1'b0;
        @(negedge clk);
        numTaps = 6'd33;
        for (int j = 0; j < 33; j++) runSample(1'b0, 3'sd3, v, s, lat);
        check("satPosVal", v, 32767);
        check("satPosFlag", longint'(s), 1);
        for (int j = 0; j < 33; j++) runSample(1'b0, 3'b100, v, s, lat);
        check("satNegVal", v, -32768);
        check("satNegFlag", longint'(s), 1);

        // Rounding shift on the SHIFT=2 instance.
        coeffUpdate2 = 1'b1;
        @(negedge clk);
        coefWrite(6'd0, 16'd6);
        coeffUpdate2 = 1'b0;
        @(negedge clk);
        numTaps = 6'd1;
        runSample(1'b1, 3'sd1, v, s, lat);
        check("shiftPos", v, 2);
        check("shiftPosSat", longint'(s), 0);
        runSample(1'b1, 3'b111, v, s, lat);
        check("shiftNeg", v, -1);

        // Overrun: second strobe inside ACC is dropped without disturbing the computation.
        numTaps = 6'd33;
        nValid = 0; nOv = 0;
        for (int i = 0; i < 60; i++) begin
            enSample = (i == 0 || i == 10);
            firIn = (i == 10) ? 3'sd2 : 3'sd1;
            @(negedge clk);
            if (valid) nValid++;
            if (overrun) nOv++;
            if (i == 5) check("accBusy", longint'(busy), 1);
        end
        enSample = 1'b0;
        check("ovrValidCount", longint'(nValid), 1);
        check("ovrPulseCount", longint'(nOv), 1);
        check("ovrOutput", longint'(firOut), -32768);
        // Line should be [0, 1, -4, ...]; a shifted-in 2 would push this to saturation.
        numTaps = 6'd2;
        runSample(1'b0, 3'sd0, v, s, lat);
        check("ovrDropped", v, 32767);
        check("ovrDroppedSat", longint'(s), 0);

        // Reset mid-ACC aborts the computation and clears the bank.
        coefRead(6'd5, rd);
        check("rdBeforeRst", longint'(rd), 32767);
        numTaps = 6'd33;
        enSample = 1'b1; firIn = 3'sd1;
        @(negedge clk);
        enSample = 1'b0;
        repeat (5) @(negedge clk);
        check("busyBeforeRst", longint'(busy), 1);
        #1 rstN = 1'b0;
        #1;
        check("midRstFirOut", longint'(firOut), 0);
        check("midRstRdDt", longint'(rdDt), 0);
        check("midRstBusy", longint'(busy), 0);
        check("midRstSat", longint'(sat), 0);
        nValid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 2) rstN = 1'b1;
            if (valid) nValid++;
        end
        check("noValidAfterRst", longint'(nValid), 0);
        coefRead(6'd5, rd);
        check("bankCleared", longint'(rd), 0);
        runSample(1'b0, 3'sd1, v, s, lat);
        check("impAfterRst", v, 0);
        check("latAfterRst", longint'(lat), 34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_fir_mac.md
Name: param_fir_mac

Overview:
Parametrised, reconfigurable FIR filter and the successor to the fixed 33-tap transposed filter. Computes each output with one time-multiplexed MAC over the sample period (one tap per clock). Coefficients load into an internal register bank through a RAM-style CSN/WRN port, with readback. Adds four things the fixed filter lacks: runtime tap count, rounding shift with saturation, output-valid strobe, and overrun detection. Sits between the sample-rate input source and the downstream 16-bit datapath.

Parameters:
- IN_W, 3: signed input sample width.
- COEFF_W, 16: signed coefficient width.
- OUT_W, 16: signed output width.
- MAX_TAPS, 33: coefficient bank depth and delay-line length.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.
- ADDR_W, 6: coefficient address width; must satisfy 2^ADDR_W > MAX_TAPS.

Ports:
- iClk_12M  in  1  system clock.
- iRsn  in  1  asynchronous active-low reset.
- iEnSample  in  1  one-cycle sample strobe.
- iCoeffUpdate  in  1  level; requests coefficient load mode.
- iCsnCoeff  in  1  coefficient port chip select, active low.
- iWrnCoeff  in  1  0 = write, 1 = read.
- iAddrCoeff  in  ADDR_W  coefficient address.
- iWrDtCoeff  in  COEFF_W  write data, signed.
- oRdDtCoeff  out  COEFF_W  readback data.
- iNumOfTaps  in  ADDR_W  active tap count.
- iFirIn  in  IN_W  input sample, signed.
- oFirOut  out  OUT_W  filtered output, signed.
- oValid  out  1  one-cycle strobe: new oFirOut.
- oSat  out  1  set when the current oFirOut was saturated.
- oBusy  out  1  high whenever state is not IDLE.
- oOverrun  out  1  one-cycle pulse: sample dropped.

Behaviour:
- Reset (asynchronous, iRsn=0):
  - State IDLE.
  - Coefficient bank, delay line, accumulator and tap index all cleared to 0.
  - oFirOut=0, oRdDtCoeff=0, oValid=0, oSat=0, oBusy=0, oOverrun=0.
  - Reset during ACC aborts the computation; no oValid is produced.
- FSM states: IDLE, LOAD, ACC, DONE.
- IDLE:
  - iCoeffUpdate=1 → LOAD. This has priority over iEnSample.
  - Otherwise, iEnSample=1:
    - Delay line shifts: x[0]←iFirIn, x[k]←x[k-1].
    - N latches as iNumOfTaps, with 0→1 and values >MAX_TAPS clamped to MAX_TAPS.
    - acc←0, idx←0, → ACC.
- LOAD:
  - Write when CSN=0 and WRN=0: coeff[addr]←iWrDtCoeff. Writes with addr≥MAX_TAPS are ignored.
  - Read when CSN=0 and WRN=1: oRdDtCoeff←coeff[addr] on the next edge; 0 if addr≥MAX_TAPS. oRdDtCoeff holds otherwise.
  - iEnSample in LOAD shifts the delay line but computes nothing, and does not raise oOverrun.
  - iCoeffUpdate=0 → IDLE.
- Coefficient port in other states: writes are ignored; reads are still serviced.
- ACC:
  - Each edge: acc←acc + x[idx]*coeff[idx], then idx←idx+1.
  - After N MAC edges → DONE.
  - ACC_W = IN_W + COEFF_W + clog2(MAX_TAPS) (25 at defaults), so the accumulator never wraps.
- DONE (one cycle):
  - r = (acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, i.e. round half-up.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. oSat←1 if clipped, else 0.
  - oFirOut←r (saturated), oValid←1 for one cycle, → IDLE. If iCoeffUpdate=1, → LOAD instead.
  - oFirOut and oSat hold between valids.
- Latency: the sample strobe is captured at edge E0, MACs occur at E1..EN, and oFirOut/oValid update at E(N+1). Minimum sample spacing is N+2 cycles.
- Overrun: iEnSample in ACC or DONE causes:
  - the sample is dropped and the delay line is unchanged;
  - oOverrun pulses for one cycle;
  - the computation in progress is unaffected.
- iCoeffUpdate asserted during ACC: the computation completes, then → LOAD.
- iNumOfTaps changes outside the sampling edge have no effect on the computation in progress.

Decomposition:
- Package fir_mac_pkg holds:
  - state enum;
  - ACC_W localparam function;
  - saturate/round function.
- One sub-module, fir_coeff_bank: a MAX_TAPS × COEFF_W register file with:
  - a write port;
  - a registered readback port;
  - a combinational MAC read port indexed by idx.
- The delay line, FSM and MAC stay in param_fir_mac.

Test Plan:
1. Load coeff[k]=k+1 for k=0..32 → read addr 5 gives 6 after one edge; read addr 40 gives 0; write to addr 40 changes nothing.
2. Defaults, N=33, impulse iFirIn=1 then 0, strobe every 40 cycles → oFirOut = 1, 2, …, 33, then 0. Each oValid arrives 34 edges after its strobe; oSat=0.
3. N=10, same coefficients and impulse → outputs 1..10, then 0. N=0 → single output 1, then 0.
4. All coefficients 16'h7FFF:
   - constant input 3 → oFirOut settles at 32767 with oSat=1;
   - constant input -4 → oFirOut settles at -32768 with oSat=1.
5. SHIFT=2 instance, coeff[0]=6, other coefficients 0, input 1 → oFirOut=2 (6+2=8, 8>>>2=2). Input -1 → -1 (-6+2=-4, -4>>>2=-1).
6. Two strobes 10 cycles apart with N=33 → one oValid, oOverrun pulses once. Then iRsn=0 mid-ACC → all outputs 0 with no oValid; after release, an impulse gives 0 output because the coefficients were cleared.
